// File: rtl/usr_pkg.sv
// usr_pkg: mode encoding, data reset value and rotate-aware shift decode for univ_shift_reg_p.
package usr_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } usr_mode_t;
  localparam logic [63:0] USR_DATA_RST = 64'h0;
  // Rotate codes decode as HOLD unless USR_ROTATE_EN is defined.
  function automatic logic is_shift(input usr_mode_t m);
`ifdef USR_ROTATE_EN
    return m inside {M_SHR, M_SHL, M_ASR, M_ROR, M_ROL};
`else
    return m inside {M_SHR, M_SHL, M_ASR};
`endif
  endfunction
endpackage

// File: rtl/usr_barrel.sv
// usr_barrel: combinational shift/rotate of one word; rotate paths exist only with USR_ROTATE_EN.
module usr_barrel
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  usr_mode_t        mode,
  input  logic             fill_r,
  input  logic             fill_l,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] ones, msb_fill, srl, sll;
`ifdef USR_ROTATE_EN
  logic [WIDTH-1:0] ror, rol;
`endif
  always_comb begin
    ones = '1;
    msb_fill = ((mode == M_ASR) ? data_in[WIDTH-1] : fill_r) ? ~(ones >> shamt) : '0;
    srl = (data_in >> shamt) | msb_fill;
    sll = (data_in << shamt) | (fill_l ? ~(ones << shamt) : '0);
    data_out = (mode == M_SHL) ? sll : (mode == M_SHR || mode == M_ASR) ? srl : data_in;
`ifdef USR_ROTATE_EN
    ror = WIDTH'({data_in, data_in} >> shamt);
    rol = WIDTH'(({data_in, data_in} << shamt) >> WIDTH);
    data_out = (mode == M_ROR) ? ror : (mode == M_ROL) ? rol : data_out;
`endif
  end
endmodule

// File: rtl/univ_shift_reg_p.sv
// univ_shift_reg_p: universal shift register with load/clear, shift-bit accounting and word_done pulse.
// Rotate modes are enabled by defining USR_ROTATE_EN.
module univ_shift_reg_p
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic             shift_right,
  input  logic             shift_left,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] data_out,
  output logic             word_done,
  output logic [SHW-1:0]   bit_cnt
);
  localparam logic [SHW:0] W_LIM = (SHW+1)'(WIDTH);
  usr_mode_t op;
  logic [SHW-1:0] amt;
  logic [SHW:0] sum;
  logic adv, wrap, clr_cnt;
  logic [WIDTH-1:0] shifted;
  // Out-of-range amounts fold modulo WIDTH; zero amounts neither shift nor count.
  always_comb begin
    op = usr_mode_t'(mode);
    amt = SHW'(32'(shamt) % WIDTH);
    adv = en && is_shift(op) && amt != '0;
    sum = {1'b0, bit_cnt} + {1'b0, amt};
    wrap = sum >= W_LIM;
    clr_cnt = en && (op == M_LOAD || op == M_CLR);
  end
  usr_barrel #(.WIDTH(WIDTH), .SHW(SHW)) u_barrel (
    .data_in (data_out),
    .shamt   (amt),
    .mode    (op),
    .fill_r  (shift_right),
    .fill_l  (shift_left),
    .data_out(shifted)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= WIDTH'(USR_DATA_RST);
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= adv && wrap;
      bit_cnt   <= clr_cnt ? '0 : adv ? (wrap ? SHW'(sum - W_LIM) : SHW'(sum)) : bit_cnt;
      if (en)
        data_out <= (op == M_LOAD) ? parallel_in : (op == M_CLR) ? '0 : adv ? shifted : data_out;
    end
  end
endmodule

// File: doc/univ_shift_reg_p.md
UNIV_SHIFT_REG_P -- requirements
Module: univ_shift_reg_p

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of shift-amount and bit-count fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  operation enable; 0 = hold all state, ignore mode.
REQ-006 mode  input  3  operation select, encoding per REQ-010.
REQ-007 shamt  input  SHW  shift/rotate amount per cycle, 0..WIDTH-1.
REQ-008 shift_right, shift_left, parallel_in, data_out, word_done and bit_cnt ports:
- shift_right  input  1  serial fill bit for right shifts, entering at MSB side.
- shift_left  input  1  serial fill bit for left shifts, entering at LSB side.
- parallel_in  input  WIDTH  parallel load word.
- data_out  output  WIDTH  register contents.
- word_done  output  1  one-cycle pulse when WIDTH cumulative bits shifted.
- bit_cnt  output  SHW  cumulative shifted-bit count modulo WIDTH.

Function
REQ-010 The block SHALL decode mode when en=1 as follows:
- 000 HOLD
- 001 SHR logical: shift right by shamt; vacated MSBs all = shift_right.
- 010 SHL: shift left by shamt; vacated LSBs all = shift_left.
- 011 LOAD: data_out <= parallel_in.
- 100 ROR
- 101 ROL
- 110 ASR: vacated MSBs = old data_out[WIDTH-1].
- 111 CLR: data_out <= 0.
REQ-011 shamt=0 with any shift/rotate mode SHALL leave data_out unchanged and SHALL NOT advance bit_cnt.
REQ-012 Latency SHALL be one cycle: the result of an operation is visible on data_out the edge after it is sampled.
REQ-013 bit_cnt SHALL advance by shamt on every SHR, SHL, ROR, ROL or ASR operation with en=1.
REQ-014 When bit_cnt+shamt >= WIDTH, word_done SHALL pulse high for exactly one cycle (registered) and bit_cnt SHALL wrap to bit_cnt+shamt-WIDTH.
REQ-015 LOAD and CLR SHALL reset bit_cnt to 0 and SHALL NOT assert word_done.
REQ-016 HOLD, or en=0, SHALL keep data_out and bit_cnt unchanged and SHALL drive word_done 0.
REQ-017 shamt >= WIDTH is illegal; the block SHALL treat it as shamt modulo WIDTH, with no assertion or error.

Reset
REQ-020 reset=0 SHALL immediately (asynchronously) force data_out=0, bit_cnt=0 and word_done=0.
REQ-021 Reset release SHALL take effect at the next clk edge; an operation sampled on that edge proceeds normally.
REQ-022 Reset asserted mid-accumulation SHALL discard any partial bit_cnt without asserting word_done.

Configuration
REQ-030 Macro USR_ROTATE_EN SHALL control the rotate modes.
- Defined: ROR and ROL (100, 101) operate per REQ-010.
- Undefined: codes 100 and 101 behave as HOLD, no rotate logic is synthesised, and bit_cnt does not advance.

Structure
REQ-040 Package usr_pkg SHALL hold:
- the mode encoding as a typedef enum, usr_mode_t (3 bits);
- a localparam for the reset value of data_out.
REQ-041 Combinational sub-module usr_barrel (WIDTH-parameterised) SHALL compute the shifted/rotated word from data_in, shamt, mode and the fill bits.
REQ-042 All registers SHALL reside in univ_shift_reg_p.

Verification
REQ-050 WIDTH=8: LOAD 0xA5, then SHR shamt=1 with shift_right=1 -> 0xD2; then SHL shamt=3 with shift_left=0 -> 0x90.
REQ-051 WIDTH=8: LOAD 0x81, then ASR shamt=2 -> 0xE0; then (USR_ROTATE_EN defined) ROL shamt=4 -> 0x0E.
REQ-052 WIDTH=8: after LOAD, three SHR shamt=3 operations:
- bit_cnt = 3, then 6, then 1;
- word_done pulses only on the third operation's result cycle.
REQ-053 en=0 with mode=SHL for 5 cycles -> data_out, bit_cnt unchanged and word_done=0; mode=111 with en=1 -> data_out=0x00 and bit_cnt=0.
REQ-054 Reset pulled low mid-cycle with data_out=0x5A and bit_cnt=5 -> all outputs 0 before the next edge; first post-reset LOAD 0x3C -> 0x3C.
REQ-055 USR_ROTATE_EN undefined: LOAD 0x0F, then mode=100 shamt=2 -> data_out stays 0x0F and bit_cnt stays 0.
